// File: rtl/cbus_arbiter_pkg.sv
// Shared CBus types and arbiter state encoding for cbus_arbiter.
// Latency: n/a (types and pure helper functions only).
// Backpressure: n/a.
package cbus_arbiter_pkg;

    // Burst encodings carried in cbus_req_t.burst (the arbiter never interprets them).
    localparam logic [1:0] CBUS_BURST_FIXED = 2'd0;
    localparam logic [1:0] CBUS_BURST_INCR  = 2'd1;

    // Request from a CBus master; len is beats-1 for INCR bursts, 0 for FIXED.
    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [3:0]  len;
        logic [1:0]  burst;
        logic [7:0]  strobe;
        logic [63:0] data;
    } cbus_req_t;

    // Response from a CBus slave; last marks the final ready beat of a transaction.
    typedef struct packed {
        logic        ready;
        logic        last;
        logic [63:0] data;
    } cbus_resp_t;

    // Arbiter FSM state.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1
    } cbus_arb_state_t;

    // Increment an index modulo n (wraps to 0 past n-1).
    function automatic int unsigned cbus_wrap_inc(int unsigned v, int unsigned n);
        if (v + 1 >= n) begin
            return 0;
        end
        return v + 1;
    endfunction

endpackage

// File: rtl/cbus_arbiter_if.sv
// Bundle of the N upstream CBus ports and the single downstream port.
// Latency: n/a (wiring only).
// Backpressure: carried by the ready bit inside cbus_resp_t.
interface cbus_arbiter_if
    import cbus_arbiter_pkg::*;
#(
    parameter int NUM_MASTER = 2
);

    cbus_req_t  ireqs  [NUM_MASTER];
    cbus_resp_t iresps [NUM_MASTER];
    cbus_req_t  oreq;
    cbus_resp_t oresp;

    // Arbiter view: consumes master requests and the slave response.
    modport slave (
        input  ireqs,
        input  oresp,
        output iresps,
        output oreq
    );

    // Environment view: drives master requests and the slave response.
    modport master (
        output ireqs,
        output oresp,
        input  iresps,
        input  oreq
    );

endinterface

// File: rtl/cbus_rr_picker.sv
// Combinational pick of the next master to grant from a request-valid vector.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when to consume the pick.
// Build option: CBUS_ARB_FIXED_PRIO_EN selects lowest-index-wins instead of round-robin.
module cbus_rr_picker #(
    parameter int NUM_MASTER = 2,
    parameter int MW         = (NUM_MASTER > 1) ? $clog2(NUM_MASTER) : 1
) (
    input  logic [NUM_MASTER-1:0] valid,
    input  logic [MW-1:0]         prio,
    output logic                  any_valid,
    output logic [MW-1:0]         pick
);

`ifdef CBUS_ARB_FIXED_PRIO_EN

    // Lowest valid index wins; the rotation pointer is deliberately ignored.
    always_comb begin
        any_valid = |valid;
        pick      = '0;
        for (int i = NUM_MASTER - 1; i >= 0; i--) begin
            if (valid[i]) begin
                pick = MW'(i);
            end
        end
    end

`else

    logic          found;
    logic [MW-1:0] idx;
    int            idx_i;

    // Scan prio, prio+1, ... modulo NUM_MASTER and keep the first valid index.
    always_comb begin
        any_valid = |valid;
        pick      = '0;
        found     = 1'b0;
        idx       = '0;
        idx_i     = 0;
        for (int i = 0; i < NUM_MASTER; i++) begin
            idx_i = (int'(prio) + i) % NUM_MASTER;
            idx   = MW'(idx_i);
            if (!found && valid[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

`endif

endmodule

// File: rtl/cbus_arbiter.sv
// N-master to 1-slave CBus arbiter; holds one grant for a whole transaction, then re-arbitrates.
// Latency: grant 1 cycle after a valid request is seen in IDLE; request/response paths 0 cycles while BUSY.
// Backpressure: losing masters see ready=0 until granted; the granted master sees the slave's ready directly.
// Build option: CBUS_ARB_FIXED_PRIO_EN freezes the priority pointer at 0 (fixed priority).
module cbus_arbiter
    import cbus_arbiter_pkg::*;
#(
    parameter int NUM_MASTER = 2
) (
    input  logic           clk,
    input  logic           reset,
    cbus_arbiter_if.slave  bus
);

    localparam int MW = (NUM_MASTER > 1) ? $clog2(NUM_MASTER) : 1;

    cbus_arb_state_t       state;
    logic [MW-1:0]         select;
    logic [MW-1:0]         prio;

    logic [NUM_MASTER-1:0] req_valid;
    logic                  any_valid;
    logic [MW-1:0]         pick;
    logic                  txn_done;

    // Gather the per-master valid bits for the picker.
    always_comb begin
        req_valid = '0;
        for (int i = 0; i < NUM_MASTER; i++) begin
            req_valid[i] = bus.ireqs[i].valid;
        end
    end

    cbus_rr_picker #(
        .NUM_MASTER (NUM_MASTER),
        .MW         (MW)
    ) u_picker (
        .valid     (req_valid),
        .prio      (prio),
        .any_valid (any_valid),
        .pick      (pick)
    );

    // The transaction ends on the slave's final ready beat.
    assign txn_done = bus.oresp.ready && bus.oresp.last;

    // Grant FSM: latch a pick in IDLE, hold it until last, always pass back through IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            select <= '0;
            prio   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        select <= pick;
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    // Other masters' valid bits are ignored here: the grant is locked until last.
                    if (txn_done) begin
                        state <= IDLE;
`ifdef CBUS_ARB_FIXED_PRIO_EN
                        prio  <= '0;
`else
                        prio  <= MW'(cbus_wrap_inc(32'(select), 32'(NUM_MASTER)));
`endif
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Route the granted master to the slave and the slave response back to that master only.
    // Everything is zero in IDLE, which also covers reset since reset forces IDLE asynchronously.
    always_comb begin
        bus.oreq = '0;
        for (int i = 0; i < NUM_MASTER; i++) begin
            bus.iresps[i] = '0;
        end
        if (state == BUSY) begin
            bus.oreq           = bus.ireqs[select];
            bus.iresps[select] = bus.oresp;
        end
    end

endmodule

// File: tb/tb_cbus_arbiter.sv
// Directed bench for cbus_arbiter with a queue-based scoreboard and a beat monitor.
// Latency: n/a.
// Backpressure: the slave model is always ready while a request is presented.
module tb_cbus_arbiter;
    import cbus_arbiter_pkg::*;

    localparam int NM = 2;

    logic clk;
    logic reset;

    cbus_arbiter_if #(.NUM_MASTER(NM)) bus ();

    cbus_arbiter #(.NUM_MASTER(NM)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int          m;
        logic [31:0] addr;
        logic        is_write;
        logic [3:0]  len;
        logic [1:0]  burst;
        logic [7:0]  strobe;
        logic [63:0] data;
        int          beat;
    } exp_t;

    exp_t        sb [$];
    int          checks   = 0;
    int          failures = 0;
    logic        prev_valid = 1'b0;
    logic [3:0]  beat_cnt;
    exp_t        mon_e;
    int          mon_g;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Read data the slave model returns for a given address and beat.
    function automatic logic [63:0] slave_data(logic [31:0] a, int b);
        return {24'hC0FFEE, 8'(b), a};
    endfunction

    task automatic check(string name, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
        end
    endtask

    // Slave model: always ready, asserts last on beat len.
    always_comb begin
        bus.oresp       = '0;
        bus.oresp.ready = bus.oreq.valid;
        bus.oresp.last  = bus.oreq.valid && (beat_cnt == bus.oreq.len);
        bus.oresp.data  = bus.oreq.valid ? slave_data(bus.oreq.addr, int'(beat_cnt)) : 64'd0;
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) beat_cnt <= '0;
        else if (bus.oresp.ready) beat_cnt <= bus.oresp.last ? 4'd0 : beat_cnt + 4'd1;
    end

    // Monitor: every accepted beat is compared against the head of the scoreboard.
    always @(negedge clk) begin
        if (reset && bus.oreq.valid && bus.oresp.ready) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 64'd1, 64'd0);
            end else begin
                mon_e = sb.pop_front();
                mon_g = -1;
                for (int i = 0; i < NM; i++) begin
                    if (bus.iresps[i].ready && mon_g < 0) mon_g = i;
                end
                check("grant_idx", 64'(mon_g), 64'(mon_e.m));
                check("oreq_addr", 64'(bus.oreq.addr), 64'(mon_e.addr));
                check("oreq_is_write", 64'(bus.oreq.is_write), 64'(mon_e.is_write));
                check("oreq_len", 64'(bus.oreq.len), 64'(mon_e.len));
                check("oreq_burst", 64'(bus.oreq.burst), 64'(mon_e.burst));
                check("oreq_strobe", 64'(bus.oreq.strobe), 64'(mon_e.strobe));
                check("oreq_data", bus.oreq.data, mon_e.data);
                for (int i = 0; i < NM; i++) begin
                    if (i != mon_e.m) check("other_iresp_zero", 64'(bus.iresps[i] != '0), 64'd0);
                end
                check("iresp_last", 64'(bus.iresps[mon_e.m].last), 64'(mon_e.beat == int'(mon_e.len)));
                check("iresp_data", bus.iresps[mon_e.m].data, slave_data(mon_e.addr, mon_e.beat));
                if (mon_e.beat == 0) check("idle_gap", 64'(prev_valid), 64'd0);
            end
        end
        prev_valid = bus.oreq.valid;
    end

    task automatic expect_beats(int m, logic [31:0] addr, logic wr, logic [3:0] len,
                                logic [1:0] burst, logic [7:0] strb, logic [63:0] data,
                                int first, int count);
        exp_t e;
        for (int b = first; b < first + count; b++) begin
            e.m = m; e.addr = addr; e.is_write = wr; e.len = len; e.burst = burst;
            e.strobe = strb; e.data = data; e.beat = b;
            sb.push_back(e);
        end
    endtask

    task automatic expect_txn(int m, logic [31:0] addr, logic wr, logic [3:0] len,
                              logic [1:0] burst, logic [7:0] strb, logic [63:0] data);
        expect_beats(m, addr, wr, len, burst, strb, data, 0, int'(len) + 1);
    endtask

    task automatic drive_req(int m, logic [31:0] addr, logic wr, logic [3:0] len,
                             logic [1:0] burst, logic [7:0] strb, logic [63:0] data);
        cbus_req_t r;
        r = '0;
        r.valid = 1'b1; r.is_write = wr; r.addr = addr; r.size = 3'd3;
        r.len = len; r.burst = burst; r.strobe = strb; r.data = data;
        bus.ireqs[m] = r;
    endtask

    // Wait (bounded) for the master's last beat, then drop valid just after that edge.
    task automatic wait_last(int m, string name);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
            if (bus.iresps[m].ready && bus.iresps[m].last) done = 1'b1;
        end
        check(name, 64'(done), 64'd1);
        if (done) begin
            @(posedge clk);
            #1;
        end
        bus.ireqs[m].valid = 1'b0;
    endtask

    task automatic run_txn(int m, logic [31:0] addr, logic wr, logic [3:0] len,
                           logic [1:0] burst, logic [7:0] strb, logic [63:0] data, string name);
        drive_req(m, addr, wr, len, burst, strb, data);
        wait_last(m, name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < NM; i++) bus.ireqs[i] = '0;
        reset = 1'b1;
        #1 reset = 1'b0;

        // 1: reset with both masters valid, then grant one cycle after release.
        expect_txn(0, 32'h0000_0100, 1'b0, 4'd0, CBUS_BURST_FIXED, 8'h00, 64'd0);
        expect_txn(1, 32'h0000_0200, 1'b0, 4'd0, CBUS_BURST_FIXED, 8'h00, 64'd0);
        fork
            run_txn(0, 32'h0000_0100, 1'b0, 4'd0, CBUS_BURST_FIXED, 8'h00, 64'd0, "t1_m0_done");
            run_txn(1, 32'h0000_0200, 1'b0, 4'd0, CBUS_BURST_FIXED, 8'h00, 64'd0, "t1_m1_done");
            begin
                repeat (3) @(negedge clk);
                check("t1_rst_oreq_valid", 64'(bus.oreq.valid), 64'd0);
                check("t1_rst_iresp0", 64'(bus.iresps[0] != '0), 64'd0);
                check("t1_rst_iresp1", 64'(bus.iresps[1] != '0), 64'd0);
                reset = 1'b1;
                #1;
                check("t1_idle_after_release", 64'(bus.oreq.valid), 64'd0);
                @(posedge clk);
                #1;
                check("t1_grant_valid", 64'(bus.oreq.valid), 64'd1);
                check("t1_grant_addr", 64'(bus.oreq.addr), 64'h0000_0100);
            end
        join
        repeat (2) @(posedge clk);
        #1;

        // 2: single FIXED read from m1.
        expect_txn(1, 32'h8000_0010, 1'b0, 4'd0, CBUS_BURST_FIXED, 8'h00, 64'd0);
        drive_req(1, 32'h8000_0010, 1'b0, 4'd0, CBUS_BURST_FIXED, 8'h00, 64'd0);
        @(posedge clk);
        #1;
        check("t2_oreq_addr", 64'(bus.oreq.addr), 64'h8000_0010);
        check("t2_m1_last", 64'(bus.iresps[1].last), 64'd1);
        check("t2_m1_ready", 64'(bus.iresps[1].ready), 64'd1);
        check("t2_m0_zero", 64'(bus.iresps[0] != '0), 64'd0);
        @(posedge clk);
        #1;
        bus.ireqs[1].valid = 1'b0;
        check("t2_back_idle", 64'(bus.oreq.valid), 64'd0);
        repeat (2) @(posedge clk);
        #1;

        // 3: contention, both INCR len=3 at once; m0 first, then m1.
        expect_txn(0, 32'h0000_1000, 1'b0, 4'd3, CBUS_BURST_INCR, 8'h00, 64'h0000_0000_0000_00A0);
        expect_txn(1, 32'h0000_2000, 1'b0, 4'd3, CBUS_BURST_INCR, 8'h00, 64'h0000_0000_0000_00B1);
        fork
            run_txn(0, 32'h0000_1000, 1'b0, 4'd3, CBUS_BURST_INCR, 8'h00, 64'h0000_0000_0000_00A0, "t3_m0_done");
            run_txn(1, 32'h0000_2000, 1'b0, 4'd3, CBUS_BURST_INCR, 8'h00, 64'h0000_0000_0000_00B1, "t3_m1_done");
        join
        repeat (2) @(posedge clk);
        #1;

        // 4: m0 issues three back-to-back transactions while m1 issues one.
`ifdef CBUS_ARB_FIXED_PRIO_EN
        expect_txn(0, 32'h0000_5000, 1'b0, 4'd1, CBUS_BURST_INCR, 8'h00, 64'd1);
        expect_txn(0, 32'h0000_5100, 1'b0, 4'd1, CBUS_BURST_INCR, 8'h00, 64'd2);
        expect_txn(0, 32'h0000_5200, 1'b0, 4'd1, CBUS_BURST_INCR, 8'h00, 64'd3);
        expect_txn(1, 32'h0000_6000, 1'b0, 4'd1, CBUS_BURST_INCR, 8'h00, 64'd4);
`else
        expect_txn(0, 32'h0000_5000, 1'b0, 4'd1, CBUS_BURST_INCR, 8'h00, 64'd1);
        expect_txn(1, 32'h0000_6000, 1'b0, 4'd1, CBUS_BURST_INCR, 8'h00, 64'd4);
        expect_txn(0, 32'h0000_5100, 1'b0, 4'd1, CBUS_BURST_INCR, 8'h00, 64'd2);
        expect_txn(0, 32'h0000_5200, 1'b0, 4'd1, CBUS_BURST_INCR, 8'h00, 64'd3);
`endif
        fork
            begin
                run_txn(0, 32'h0000_5000, 1'b0, 4'd1, CBUS_BURST_INCR, 8'h00, 64'd1, "t4_m0a_done");
                run_txn(0, 32'h0000_5100, 1'b0, 4'd1, CBUS_BURST_INCR, 8'h00, 64'd2, "t4_m0b_done");
                run_txn(0, 32'h0000_5200, 1'b0, 4'd1, CBUS_BURST_INCR, 8'h00, 64'd3, "t4_m0c_done");
            end
            run_txn(1, 32'h0000_6000, 1'b0, 4'd1, CBUS_BURST_INCR, 8'h00, 64'd4, "t4_m1_done");
        join
        repeat (2) @(posedge clk);
        #1;

        // 5: async reset between beats 2 and 3 of an INCR len=7, then restart from beat 0.
        expect_beats(0, 32'h0000_3000, 1'b0, 4'd7, CBUS_BURST_INCR, 8'h00, 64'h55, 0, 3);
        drive_req(0, 32'h0000_3000, 1'b0, 4'd7, CBUS_BURST_INCR, 8'h00, 64'h55);
        repeat (4) @(posedge clk);
        #2;
        check("t5_pre_reset_valid", 64'(bus.oreq.valid), 64'd1);
        reset = 1'b0;
        #1;
        check("t5_reset_oreq_valid", 64'(bus.oreq.valid), 64'd0);
        check("t5_reset_iresp0", 64'(bus.iresps[0] != '0), 64'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        expect_txn(0, 32'h0000_3000, 1'b0, 4'd7, CBUS_BURST_INCR, 8'h00, 64'h55);
        #1;
        check("t5_idle_after_release", 64'(bus.oreq.valid), 64'd0);
        @(posedge clk);
        #1;
        check("t5_regrant_valid", 64'(bus.oreq.valid), 64'd1);
        check("t5_regrant_beat0_last", 64'(bus.iresps[0].last), 64'd0);
        wait_last(0, "t5_m0_done");
        repeat (2) @(posedge clk);
        #1;

        // 6: write passthrough of strobe/data/is_write.
        expect_txn(0, 32'h0000_4000, 1'b1, 4'd0, CBUS_BURST_FIXED, 8'h0F, 64'hDEAD_BEEF_1234_5678);
        drive_req(0, 32'h0000_4000, 1'b1, 4'd0, CBUS_BURST_FIXED, 8'h0F, 64'hDEAD_BEEF_1234_5678);
        @(posedge clk);
        #1;
        check("t6_strobe", 64'(bus.oreq.strobe), 64'h0F);
        check("t6_data", bus.oreq.data, 64'hDEAD_BEEF_1234_5678);
        check("t6_is_write", 64'(bus.oreq.is_write), 64'd1);
        check("t6_m0_ready", 64'(bus.iresps[0].ready), 64'd1);
        @(posedge clk);
        #1;
        bus.ireqs[0].valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
